// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
// Holds the FSM state encoding and the chip-register power-on table.
package spi_cfg_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  function automatic logic [DATA_W-1:0] reg_default(input logic [ADDR_W-1:0] a);
    case (a)
      4'h0: return 12'h029;
      4'h1: return 12'h000;
      4'h2: return 12'h000;
      4'h3: return 12'h0a0;
      4'h4: return 12'h002;
      4'h5: return 12'h000;
      4'h6: return 12'h000;
      4'h7: return 12'h1e1;
      4'h8: return 12'h04a;
      4'h9: return 12'h06b;
      4'ha: return 12'h055;
      4'hb: return 12'h0f0;
      4'hc: return 12'hff0;
      4'hd: return 12'hadf;
      4'he: return 12'h6db;
      default: return 12'h0db;
    endcase
  endfunction

endpackage

// File: rtl/spi_cfg_regfile.sv
// Shadow table of chip-register values: one write port, combinational read.
// Reset restores the power-on defaults; writes land on the next clock edge.
module spi_cfg_regfile
  import spi_cfg_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= reg_default(ADDR_W'(i));
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Uploads table entries 0..nrg as {addr,data} frames over valid/ready after a power-up delay.
// go -> frame_valid next cycle; frames held stable while stalled; GAP idle cycles between frames.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int NREG      = 16,
  parameter int PWRUP_DLY = 200,
  parameter int GAP       = 2
) (
  input  logic              clock_20,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              go,
  input  logic [ADDR_W-1:0] nrg,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam int DW = $clog2(PWRUP_DLY + 1);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);

  state_e            state_q, state_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [ADDR_W-1:0] idx_q, idx_d, last_q, last_d, nxt_idx;
  logic [DATA_W-1:0] data_q, data_d, rd_data, rd_fwd;
  logic              pend_q, pend_d, valid_q, valid_d, busy_q, busy_d;
  logic              done_q, done_d, wr_err_q, load;
  logic              wr_ok;

  assign wr_ok = wr_en && !busy_q;

  spi_cfg_regfile #(.NREG(NREG)) u_regfile (
    .clk_i     (clock_20),
    .rst_i     (reset),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (nxt_idx),
    .rd_data_o (rd_data)
  );

  // Index of the frame that would be loaded this cycle, if any.
  always_comb begin
    nxt_idx = '0;
    if (state_q == ST_SEND)     nxt_idx = idx_q + 1'b1;
    else if (state_q == ST_GAP) nxt_idx = idx_q;
  end

  // A write coinciding with go must be visible in the first frame.
  assign rd_fwd = (wr_ok && (wr_addr == nxt_idx)) ? wr_data : rd_data;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_PWRUP: begin
        if (go) pend_d = 1'b1;
        if (dly_q == DW'(PWRUP_DLY - 1)) begin
          dly_d   = DW'(PWRUP_DLY);
          state_d = ST_IDLE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (go || pend_q) begin
          pend_d  = 1'b0;
          last_d  = nrg;
          idx_d   = '0;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (valid_q && frame_ready) begin
          valid_d = 1'b0;
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d = nxt_idx;
            if (GAP == 0) begin
              load = 1'b1;
            end else begin
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (int'(gap_q) >= GAP - 1) begin
          gap_d   = '0;
          load    = 1'b1;
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    if (load) begin
      valid_d = 1'b1;
      data_d  = rd_fwd;
    end
  end

  always_ff @(posedge clock_20 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_PWRUP;
      dly_q    <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_en && busy_q;
    end
  end

  assign frame_valid = valid_q;
  assign frame_addr  = idx_q;
  assign frame_data  = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench for spi_cfg_sequencer with a frame scoreboard and stall/spacing monitor.
module tb_spi_cfg_sequencer;

  localparam int PWRUP_DLY = 200;
  localparam int GAP       = 2;

  logic        clock_20 = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        go = 1'b0;
  logic [3:0]  nrg = '0;
  logic        frame_ready = 1'b1;
  logic        frame_valid, busy, done, wr_err;
  logic [3:0]  frame_addr;
  logic [11:0] frame_data;

  spi_cfg_sequencer #(.NREG(16), .PWRUP_DLY(PWRUP_DLY), .GAP(GAP)) dut (
    .clock_20    (clock_20),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .go          (go),
    .nrg         (nrg),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .busy        (busy),
    .done        (done),
    .wr_err      (wr_err)
  );

  always #25 clock_20 = ~clock_20;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit spacing_on = 1'b0;
  logic [15:0] exp_q[$];
  logic [11:0] dflt [16];
  logic [11:0] model [16];

  always @(posedge clock_20) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard on each transfer, hold-stability during stalls, done/busy relation.
  bit          stall_hold = 1'b0;
  logic [3:0]  hold_addr;
  logic [11:0] hold_data;
  int          prev_xfer = -1;
  always @(negedge clock_20) begin
    logic [15:0] e;
    if (reset) begin
      stall_hold = 1'b0;
    end else begin
      if (stall_hold) begin
        check("hold_valid", frame_valid, 1);
        check("hold_addr", frame_addr, hold_addr);
        check("hold_data", frame_data, hold_data);
      end
      stall_hold = frame_valid && !frame_ready;
      hold_addr  = frame_addr;
      hold_data  = frame_data;
      if (!spacing_on) prev_xfer = -1;
      if (frame_valid && frame_ready) begin
        check("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("frame_addr", frame_addr, e[15:12]);
          check("frame_data", frame_data, e[11:0]);
        end
        if (spacing_on && prev_xfer >= 0) check("frame_spacing", cyc - prev_xfer, GAP + 1);
        prev_xfer = cyc;
      end
      if (done) begin
        done_cnt++;
        check("busy_low_with_done", busy, 0);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_20);
      #1;
    end
  endtask

  task automatic start_upload(input logic [3:0] n, output int d0);
    for (int i = 0; i <= int'(n); i++) exp_q.push_back({4'(i), model[i]});
    d0  = done_cnt;
    nrg = n;
    go  = 1'b1;
    tick(1);
    go  = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick(1);
    tick(3);
    check("done_once", done_cnt - d0, 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic run_upload(input logic [3:0] n, input int budget);
    int d0;
    start_upload(n, d0);
    wait_done(d0, budget);
  endtask

  task automatic wait_frame(input logic [3:0] a, input int budget);
    for (int k = 0; k < budget && !(frame_valid && frame_addr == a); k++) tick(1);
    check("reach_frame", {frame_valid, frame_addr}, {1'b1, a});
  endtask

  initial begin
    int d0, r, first;
    dflt = '{12'h029, 12'h000, 12'h000, 12'h0a0, 12'h002, 12'h000, 12'h000, 12'h1e1,
             12'h04a, 12'h06b, 12'h055, 12'h0f0, 12'hff0, 12'hadf, 12'h6db, 12'h0db};
    model = dflt;

    // Reset state
    tick(3);
    check("rst_valid", frame_valid, 0);
    check("rst_addr", frame_addr, 0);
    check("rst_data", frame_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    reset = 1'b0;
    r = cyc;

    // go during power-up is held pending until the delay expires
    tick(10);
    start_upload(4'd0, d0);
    for (int k = 0; k < PWRUP_DLY + 50 && !frame_valid; k++) tick(1);
    first = cyc - r;
    check("pwrup_delay", (first >= PWRUP_DLY) && (first <= PWRUP_DLY + 2), 1);
    check("first_addr", frame_addr, 0);
    check("first_data", frame_data, dflt[0]);
    wait_done(d0, 20);

    // Minimum latency from IDLE with ready tied high
    exp_q.push_back({4'd0, model[0]});
    d0 = done_cnt;
    go = 1'b1;
    tick(1);
    go = 1'b0;
    check("lat_valid", frame_valid, 1);
    check("lat_busy", busy, 1);
    tick(1);
    check("lat_done", done, 1);
    check("lat_busy_done", busy, 0);
    check("lat_valid_off", frame_valid, 0);
    tick(1);
    check("lat_done_pulse", done, 0);
    check("lat_done_cnt", done_cnt - d0, 1);

    // Full table, frames evenly spaced
    spacing_on = 1'b1;
    run_upload(4'd15, 100);
    spacing_on = 1'b0;

    // Write in IDLE then partial upload reads the new value
    wr_en = 1'b1; wr_addr = 4'hc; wr_data = 12'hfb0;
    model[12] = 12'hfb0;
    tick(1);
    wr_en = 1'b0;
    tick(1);
    check("idle_wr_no_err", wr_err, 0);
    run_upload(4'd12, 100);

    // Write coinciding with go is seen by the first frame
    wr_en = 1'b1; wr_addr = 4'h0; wr_data = 12'h5a5;
    model[0] = 12'h5a5;
    start_upload(4'd0, d0);
    wr_en = 1'b0;
    check("go_wr_no_err", wr_err, 0);
    wait_done(d0, 20);

    // Stall on frame 3 for five cycles
    frame_ready = 1'b1;
    start_upload(4'd5, d0);
    wait_frame(4'd3, 30);
    frame_ready = 1'b0;
    tick(5);
    check("stall_valid", frame_valid, 1);
    check("stall_addr", frame_addr, 3);
    check("stall_data", frame_data, model[3]);
    frame_ready = 1'b1;
    tick(1);
    check("stall_release", frame_valid, 0);
    wait_done(d0, 50);

    // Write, go and nrg change while busy are all ignored
    start_upload(4'd15, d0);
    tick(3);
    wr_en = 1'b1; wr_addr = 4'h7; wr_data = 12'h123;
    go = 1'b1; nrg = 4'd2;
    tick(1);
    wr_en = 1'b0; go = 1'b0;
    check("busy_wr_err", wr_err, 1);
    tick(1);
    check("busy_wr_err_pulse", wr_err, 0);
    wait_done(d0, 100);
    run_upload(4'd7, 60);

    // Reset in the middle of a stalled frame 5
    start_upload(4'd9, d0);
    wait_frame(4'd5, 40);
    frame_ready = 1'b0;
    tick(2);
    #5 reset = 1'b1;
    #1;
    check("arst_valid", frame_valid, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    frame_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(PWRUP_DLY + 5);
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_idle_valid", frame_valid, 0);

    // Table reverted to defaults
    model = dflt;
    run_upload(4'd15, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cfg_sequencer.md
Name: spi_cfg_sequencer

Overview:
- Upstream feeder for the SPI register-upload serializer.
- Holds a 16-entry shadow table of 12-bit chip-register values, writable by the host/control logic.
- On a trigger, hands the serializer one {addr, data} frame per register, in address order, over a valid/ready handshake.
- Reports busy and done; enforces a power-up delay after reset before the first upload.

Parameters:
- NREG, 16: table depth, i.e. chip registers; address width is 4.
- DATA_W, 12: register data width.
- PWRUP_DLY, 200: clock_20 cycles after reset release before an upload may start.
- GAP, 2: idle cycles between accepted frames (0 allowed).

Ports:
- clock_20  in  1  20 MHz system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  4  table write address.
- wr_data  in  12  table write data.
- go  in  1  start upload, single-cycle pulse.
- nrg  in  4  last register index to send; nrg+1 frames go out (1..16).
- frame_valid  out  1  frame available to serializer.
- frame_ready  in  1  serializer accepts frame.
- frame_addr  out  4  register address of current frame.
- frame_data  out  12  register data of current frame.
- busy  out  1  high from go acceptance until done.
- done  out  1  one-cycle pulse after last frame accepted.
- wr_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Clock and reset: one clock (clock_20); asynchronous, active-high reset.
- Reset values: frame_valid=0, frame_addr=0, frame_data=0, busy=0, done=0, wr_err=0, state=PWRUP, delay counter=0.
- Table restored on reset to: 0:029 1:000 2:000 3:0a0 4:002 5:000 6:000 7:1e1 8:04a 9:06b A:055 B:0f0 C:ff0 D:adf E:6db F:0db.
- PWRUP:
  - Counts PWRUP_DLY cycles, then moves to IDLE.
  - A go seen in PWRUP is latched as pending and starts the upload on the first IDLE cycle.
  - Table writes are allowed in PWRUP.
- IDLE, go=1 (or pending): latch nrg into last_idx, idx=0, busy=1, go to SEND.
  - frame_valid rises the cycle after go is sampled.
- SEND:
  - frame_valid=1, frame_addr=idx, frame_data=table[idx].
  - Outputs are registered and held stable while valid && !ready.
  - A transfer happens on a rising edge with valid && ready.
  - Transfer with idx==last_idx: frame_valid=0, done pulses the next cycle, busy=0 in the same cycle as done, return to IDLE.
  - Transfer with idx<last_idx: frame_valid=0, idx=idx+1, go to GAP (or straight back to SEND if GAP=0, keeping valid high for a back-to-back frame).
- GAP: counts GAP cycles with frame_valid=0, then SEND.
- Writes:
  - Accepted in PWRUP and IDLE.
  - Rejected whenever busy=1: table unchanged, wr_err pulses the next cycle.
  - A write in the same cycle as an accepted go takes effect; the first frame reads the updated table.
- go while busy: ignored, no error.
- nrg changes during an upload have no effect; last_idx is latched.
- Latency: minimum frames for nrg=0 is go → valid at +1, accept at +1 with ready tied high, done at +2.
- Reset mid-upload: frame_valid drops immediately (async), table reverts to defaults, no done pulse, PWRUP restarts.
- Width rules:
  - idx is 4 bits; it never wraps because it stops at last_idx ≤ 15.
  - Delay counter is sized to clog2(PWRUP_DLY+1) and saturates at the target.

Decomposition:
- Shared package spi_cfg_pkg holds:
  - the state enum {PWRUP, IDLE, SEND, GAP};
  - the 16×12 default register table constant;
  - the ADDR_W=4 and DATA_W=12 constants.
- Sub-module spi_cfg_regfile: 16×12 register array, async reset to package defaults, one write port and one combinational read port.
- The sequencer FSM lives in the top level.

Test Plan:
- Reset release, go at cycle 10 → no frame_valid before cycle PWRUP_DLY; upload starts on the first IDLE cycle; frame 0 is addr=0, data=029.
- nrg=15, frame_ready tied 1, GAP=2 → 16 frames, addr 0..F with default data, frames spaced 3 cycles apart, done pulses once, busy falls with done.
- Write addr=C data=fb0 in IDLE, then go with nrg=12 → 13 frames; frame 12 carries fb0.
- frame_ready held low for 5 cycles on frame 3 → valid, addr=3, data=0a0 held stable; transfer on the 6th cycle; later frames unaffected.
- Write addr=7 data=123 while busy → wr_err pulses 1 cycle; the next upload still sends 1e1 for addr 7.
- Assert reset during frame 5 with ready low → frame_valid=0 asynchronously, busy=0, no done; the table readback shows the defaults.
